// File: rtl/stream_pkg.sv
// Shared types and constants for the stream source.
// Holds the FSM state enum, pattern mode codes and LFSR polynomial.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

endpackage

// File: rtl/stream_pattern_next.sv
// Combinational next-word generator for the stream source.
// Ports: mode (pattern select), cur (current word), nxt (following word).
module stream_pattern_next
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] cur,
    output logic [DATA_WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        unique case (mode)
            MODE_INC:  nxt = cur + DATA_WIDTH'(1);
            // Galois right-shift LFSR
            MODE_LFSR: nxt = (cur >> 1)
                           ^ (cur[0] ? DATA_WIDTH'(LFSR_POLY)
                                     : '0);
            // constant and reserved modes repeat the word
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/stream_src.sv
// Pattern stream source: emits count words on a valid/ready stream.
// Ports: clk, rst, start/mode/seed/count/abort control, out_* stream,
//        busy, done pulse, sent_count progress.
module stream_src
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sent_count
);

    state_t                state;
    logic [1:0]            mode_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  abort_q;
    logic [DATA_WIDTH-1:0] nxt_word;
    logic [DATA_WIDTH-1:0] first_word;
    logic [CNT_WIDTH-1:0]  sent_nxt;
    logic                  last_nxt;
    logic                  hs;

    stream_pattern_next #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next (
        .mode (mode_q),
        .cur  (out_data),
        .nxt  (nxt_word)
    );

    // an all-zero LFSR would lock up, so it starts from 1 instead
    assign first_word = (mode == MODE_LFSR && seed == '0)
                      ? DATA_WIDTH'(1) : seed;

    assign hs       = out_valid && out_ready;
    assign sent_nxt = sent_count + CNT_WIDTH'(1);
    // the word after this handshake is last if it brings us to count
    assign last_nxt = (sent_nxt + CNT_WIDTH'(1)) == cnt_q;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_INC;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            sent_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        cnt_q      <= count;
                        abort_q    <= 1'b0;
                        sent_count <= '0;
                        if (count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_RUN;
                            out_valid <= 1'b1;
                            out_data  <= first_word;
                            out_last  <= (count == CNT_WIDTH'(1));
                        end
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        sent_count <= sent_nxt;
                        // an abort seen now or earlier ends the
                        // transfer on this handshake
                        if (out_last || abort || abort_q) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            abort_q   <= 1'b0;
                        end else begin
                            out_data <= nxt_word;
                            out_last <= last_nxt;
                        end
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_src.sv
// Self-checking bench for stream_src: directed cases plus random traffic
// compared each cycle against a transfer-level reference model.
module tb_stream_src;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic [15:0] count;
    logic        abort;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;

    int checks = 0;
    int errors = 0;

    stream_src #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .seed       (seed),
        .count      (count),
        .abort      (abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transfer is a precomputed list of words; the model only tracks
    // how many have been accepted and whether it is finishing.
    logic [31:0] exp_q[$];
    bit          m_act   = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_abort = 1'b0;
    int          m_idx   = 0;
    int          m_cnt   = 0;
    int          m_sent  = 0;

    function automatic logic [31:0] gen_next(input logic [1:0] md,
                                             input logic [31:0] w);
        logic [31:0] r;
        if (md == 2'd0)
            r = w + 32'd1;
        else if (md == 2'd1)
            r = (w >> 1) ^ (w[0] ? 32'h80200003 : 32'h0);
        else
            r = w;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   = 1'b0;
            m_done  = 1'b0;
            m_abort = 1'b0;
            m_idx   = 0;
            m_cnt   = 0;
            m_sent  = 0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_act) begin
            if (out_ready) begin
                m_sent++;
                m_idx++;
                if (m_idx == m_cnt || abort || m_abort) begin
                    m_act   = 1'b0;
                    m_done  = 1'b1;
                    m_abort = 1'b0;
                end
            end else if (abort) begin
                m_abort = 1'b1;
            end
        end else if (start) begin
            logic [31:0] w;
            m_sent  = 0;
            m_idx   = 0;
            m_abort = 1'b0;
            m_cnt   = int'(count);
            exp_q.delete();
            if (count == 16'd0) begin
                m_done = 1'b1;
            end else begin
                w = seed;
                if (mode == 2'd1 && w == 32'd0) w = 32'd1;
                for (int i = 0; i < m_cnt; i++) begin
                    exp_q.push_back(w);
                    w = gen_next(mode, w);
                end
                m_act = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", {31'd0, out_valid}, {31'd0, m_act});
        chk("busy", {31'd0, busy}, {31'd0, m_act | m_done});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("sent", {16'd0, sent_count}, m_sent);
        chk("last", {31'd0, out_last},
            {31'd0, m_act && (m_idx + 1 == m_cnt)});
        if (m_act && m_idx < exp_q.size())
            chk("data", out_data, exp_q[m_idx]);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [1:0] md, input logic [31:0] sd,
                      input logic [15:0] cn);
        mode  = md;
        seed  = sd;
        count = cn;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        seed      = 32'd0;
        count     = 16'd0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sent", {16'd0, sent_count}, 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // incrementing wraps through zero
        out_ready = 1'b1;
        go(2'd0, 32'hFFFFFFFE, 16'd3);
        chk("inc_w0", out_data, 32'hFFFFFFFE);
        chk("inc_l0", {31'd0, out_last}, 32'd0);
        step();
        chk("inc_w1", out_data, 32'hFFFFFFFF);
        chk("inc_l1", {31'd0, out_last}, 32'd0);
        step();
        chk("inc_w2", out_data, 32'h00000000);
        chk("inc_l2", {31'd0, out_last}, 32'd1);
        step();
        chk("inc_done", {31'd0, done}, 32'd1);
        chk("inc_sent", {16'd0, sent_count}, 32'd3);
        step();
        chk("inc_idle", {31'd0, busy}, 32'd0);

        // LFSR with stall
        out_ready = 1'b0;
        go(2'd1, 32'd1, 16'd2);
        chk("lfsr_s0", out_data, 32'h00000001);
        step();
        chk("lfsr_s1", out_data, 32'h00000001);
        step();
        chk("lfsr_s2", out_data, 32'h00000001);
        out_ready = 1'b1;
        step();
        chk("lfsr_w1", out_data, 32'h80200003);
        chk("lfsr_l1", {31'd0, out_last}, 32'd1);
        step();
        chk("lfsr_done", {31'd0, done}, 32'd1);
        step();

        // zero-length transfer
        go(2'd0, 32'h1234, 16'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_valid", {31'd0, out_valid}, 32'd0);
        chk("zero_sent", {16'd0, sent_count}, 32'd0);
        step();
        chk("zero_end", {31'd0, done}, 32'd0);

        // constant with abort while word 3 stalls
        go(2'd2, 32'hBBBB0002, 16'd10);
        step();
        step();
        out_ready = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abt_hold", out_data, 32'hBBBB0002);
        chk("abt_sent2", {16'd0, sent_count}, 32'd2);
        out_ready = 1'b1;
        step();
        chk("abt_done", {31'd0, done}, 32'd1);
        chk("abt_sent3", {16'd0, sent_count}, 32'd3);
        step();

        // reset mid-transfer then restart
        go(2'd0, 32'h10, 16'd5);
        step();
        chk("rr_w1", out_data, 32'h11);
        rst = 1'b1;
        #1;
        chk("rr_valid", {31'd0, out_valid}, 32'd0);
        chk("rr_sent", {16'd0, sent_count}, 32'd0);
        step();
        rst = 1'b0;
        go(2'd0, 32'h10, 16'd5);
        chk("rr_w0", out_data, 32'h10);
        chk("rr_sent0", {16'd0, sent_count}, 32'd0);
        for (int i = 0; i < 8; i++) step();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 3) == 0);
            mode      = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       seed = 32'd0;
                1:       seed = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: seed = $urandom;
            endcase
            count     = 16'($urandom_range(0, 12));
            out_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 24) == 0);
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_src.md
STREAM_SRC -- requirements
Module: stream_src

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, stream word width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, width of the word-count and progress fields.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to begin a transfer; SHALL be sampled only in IDLE.
REQ-006 mode  input  2  pattern: 0 = incrementing, 1 = LFSR, 2 = constant, 3 = reserved (treated as constant).
REQ-007 seed  input  DATA_WIDTH  first word of the transfer.
REQ-008 count  input  CNT_WIDTH  number of words to send.
REQ-009 abort  input  1  request to terminate the transfer early.
REQ-010 out_data  output  DATA_WIDTH  stream data.
REQ-011 out_valid  output  1  stream valid.
REQ-012 out_ready  input  1  downstream ready.
REQ-013 out_last  output  1  marks the final word of the transfer.
REQ-014 busy  output  1  high while not in IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 sent_count  output  CNT_WIDTH  number of handshakes completed in the current or most recent transfer.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE with start=1 and count>0 SHALL latch mode, seed and count, clear sent_count, go to RUN, and assert out_valid with out_data=seed on the next cycle.
REQ-019 IDLE with start=1 and count=0 SHALL go to DONE; out_valid SHALL never assert.
REQ-020 A handshake SHALL occur on a cycle where out_valid && out_ready.
REQ-021 A handshake SHALL increment sent_count by 1.
REQ-022 After a handshake the next word SHALL be presented on the following cycle, giving one word per cycle under sustained out_ready=1.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-024 out_valid SHALL NOT deassert before a handshake.
REQ-025 There SHALL be no combinational path from out_ready to any output.
REQ-026 Incrementing mode: next = current + 1, modulo 2^DATA_WIDTH.
REQ-027 LFSR mode: next = (current >> 1) XOR (current[0] ? LFSR_POLY : 0).
REQ-028 In LFSR mode a seed of 0 SHALL be replaced by 1.
REQ-029 Constant mode: every word SHALL equal seed.
REQ-030 out_last SHALL be 1 exactly on the word whose handshake makes sent_count equal to the latched count.
REQ-031 The handshake on the out_last word SHALL move the FSM RUN -> DONE.
REQ-032 abort=1 in RUN SHALL set an abort-pending flag.
REQ-033 With abort pending, the word currently presented SHALL still complete its handshake unmodified; that handshake SHALL then move RUN -> DONE.
REQ-034 If abort and the final handshake coincide, the transfer SHALL complete normally with out_last=1.
REQ-035 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-036 busy SHALL be 1 in RUN and DONE.
REQ-037 start SHALL be ignored outside IDLE.
REQ-038 abort SHALL be ignored outside RUN.
REQ-039 sent_count SHALL hold its final value until the next accepted start.

Reset
REQ-040 rst=1 SHALL force: FSM=IDLE, out_valid=0, out_last=0, done=0, busy=0, sent_count=0, out_data=0, abort flag cleared.
REQ-041 Reset asserted mid-transfer SHALL drop out_valid immediately; no state from the interrupted transfer SHALL survive.

Structure
REQ-042 A shared package stream_pkg SHALL hold the FSM state enum, the mode encoding constants and LFSR_POLY = 32'h80200003.
REQ-043 LFSR mode SHALL be supported for DATA_WIDTH = 32.
REQ-044 Next-word generation SHALL be one combinational sub-module, stream_pattern_next (inputs mode and current word; output next word).

Verification
REQ-045 Reset: hold rst=1 -> out_valid=0, busy=0, done=0, sent_count=0; release rst, start=0 -> outputs unchanged.
REQ-046 Incrementing, seed 32'hFFFFFFFE, count 3, out_ready=1 -> consecutive words FFFFFFFE, FFFFFFFF, 00000000; out_last only on the third; done next cycle; sent_count=3.
REQ-047 LFSR, seed 1, count 2, out_ready=0 for 3 cycles then 1 -> 00000001 held stable while stalled, then 80200003 with out_last=1.
REQ-048 count=0 with start -> done pulses one cycle later; out_valid never high; sent_count=0.
REQ-049 Constant, seed 32'hBBBB0002, count 10, abort pulsed while word 3 is stalled -> word 3 delivered, then done, sent_count=3, out_last never asserted.
REQ-050 Reset pulse during RUN at word 2, then start again -> out_valid low during reset; new transfer restarts from seed with sent_count from 0.
